// File: rtl/pico_pkg.sv
// Shared types and defaults for the pico core: decoder next-PC modes and fetch FSM states.
package pico_pkg;

  localparam int PC_WIDTH_DEFAULT    = 8;
  localparam int INSTR_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    INCREMENT = 2'd0,
    RELATIVE  = 2'd1,
    HALTCOUNT = 2'd2
  } modePC;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } fetchState;

endpackage

// File: rtl/pc_fetch_next.sv
// Combinational next-PC adder: increment, relative branch or hold, wrapping modulo 2^PC_WIDTH.
module pc_next
  import pico_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  modePC               mode,
  input  logic [PC_WIDTH-1:0] offset,
  output logic [PC_WIDTH-1:0] next_pc
);

  // offset is already PC_WIDTH wide, so two's-complement addition is the sign extension
  always_comb begin
    next_pc = pc + PC_WIDTH'(1);
    case (mode)
      RELATIVE:  next_pc = pc + PC_WIDTH'(1) + offset;
      HALTCOUNT: next_pc = pc;
      default:   ;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// PC and instruction-fetch stage of the pico core. Optional fetch watchdog: PICO_FETCH_TIMEOUT_EN.
module pc_fetch
  import pico_pkg::*;
#(
  parameter int                    PC_WIDTH      = PC_WIDTH_DEFAULT,
  parameter int                    INSTR_WIDTH   = INSTR_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0]   RESET_PC      = '0,
  parameter int                    FETCH_TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  modePC                  mode_pc_i,
  input  logic [PC_WIDTH-1:0]    offset_i,
  input  logic                   halt_core_i,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INSTR_WIDTH-1:0] imem_data_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   instr_valid_o,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic                   halted_o,
  output logic                   fetch_err_o,
  output fetchState              state_o
);

  // Handshake: imem_req_o stays high with imem_addr_o stable until a cycle in which
  // imem_ack_i is high; that cycle's imem_data_i is captured. Acks while req is low are ignored.

  fetchState             state, state_nxt;
  logic                  started;
  logic                  capture;
  logic                  advance;
  logic [PC_WIDTH-1:0]   next_pc;
`ifdef PICO_FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
  logic [CNT_W-1:0]      fetch_cnt;
  logic                  timeout;
`endif

  pc_next #(.PC_WIDTH(PC_WIDTH)) u_pc_next (
    .pc      (pc_o),
    .mode    (mode_pc_i),
    .offset  (offset_i),
    .next_pc (next_pc)
  );

  always_comb begin
    state_nxt     = state;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    capture       = 1'b0;
    advance       = 1'b0;
`ifdef PICO_FETCH_TIMEOUT_EN
    timeout       = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        // started keeps req low for the first cycle after reset so stale acks are dropped
        if (started) begin
          imem_req_o = 1'b1;
          if (imem_ack_i) begin
            capture   = 1'b1;
            state_nxt = S_EXEC;
          end
`ifdef PICO_FETCH_TIMEOUT_EN
          else if (fetch_cnt == CNT_W'(FETCH_TIMEOUT - 1)) begin
            timeout   = 1'b1;
            state_nxt = S_HALT;
          end
`endif
        end
      end
      S_EXEC: begin
        instr_valid_o = 1'b1;
        if (halt_core_i || (mode_pc_i == HALTCOUNT)) begin
          state_nxt = S_HALT;
        end else begin
          advance   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_HALT:  ;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign imem_addr_o = pc_o;
  assign state_o     = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_FETCH;
      started  <= 1'b0;
      pc_o     <= RESET_PC;
      instr_o  <= '0;
      halted_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (capture) instr_o <= imem_data_i;
      if (advance) pc_o <= next_pc;
      if (state_nxt == S_HALT) halted_o <= 1'b1;
    end
  end

`ifdef PICO_FETCH_TIMEOUT_EN
  // Counts requested-but-unacknowledged cycles of the current fetch
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt   <= '0;
      fetch_err_o <= 1'b0;
    end else begin
      if (state != S_FETCH || imem_ack_i) fetch_cnt <= '0;
      else if (started) fetch_cnt <= fetch_cnt + CNT_W'(1);
      if (timeout) fetch_err_o <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^FETCH_TIMEOUT;
  assign fetch_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed + randomized bench for pc_fetch against an arithmetic PC model and an instruction queue.
module tb_pc_fetch;
  import pico_pkg::*;

  localparam int PW = 8;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  modePC         mode_pc;
  logic [PW-1:0] offset;
  logic          halt_core;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [PW-1:0] pc;
  logic          halted;
  logic          fetch_err;
  fetchState     state;

  int            errors = 0;
  int            checks = 0;
  int            cycle  = 0;
  int            model_pc;
  int            last_valid_cycle;
  logic [IW-1:0] last_instr;
  logic [IW-1:0] exp_q[$];

  pc_fetch #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(8'd0), .FETCH_TIMEOUT(15)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mode_pc_i     (mode_pc),
    .offset_i      (offset),
    .halt_core_i   (halt_core),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_data_i   (imem_data),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .pc_o          (pc),
    .halted_o      (halted),
    .fetch_err_o   (fetch_err),
    .state_o       (state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // decoder inputs are don't-care outside the execute cycle
  task automatic drive_idle();
    mode_pc   = modePC'(2'($urandom_range(0, 2)));
    offset    = PW'($urandom);
    halt_core = 1'($urandom_range(0, 1));
  endtask

  // called just after a negedge; leaves the bench at a negedge with the first req up
  task automatic do_reset(input bit late_ack);
    rst      = 1'b1;
    imem_ack = 1'b0;
    #1;
    check("rst_req",    64'(imem_req),    64'(0));
    check("rst_pc",     64'(pc),          64'(0));
    check("rst_instr",  64'(instr),       64'(0));
    check("rst_valid",  64'(instr_valid), 64'(0));
    check("rst_halted", 64'(halted),      64'(0));
    check("rst_err",    64'(fetch_err),   64'(0));
    @(negedge clk);
    rst = 1'b0;
    if (late_ack) begin
      imem_ack  = 1'b1;
      imem_data = $urandom;
    end
    #1;
    check("req_before_start", 64'(imem_req), 64'(0));
    @(negedge clk);
    imem_ack = 1'b0;
    check("first_req",   64'(imem_req),    64'(1));
    check("first_addr",  64'(imem_addr),   64'(0));
    check("first_valid", 64'(instr_valid), 64'(0));
    model_pc         = 0;
    last_valid_cycle = -1;
    exp_q.delete();
  endtask

  // driver: memory answers after lat cycles, decoder returns (m, off, h) in the execute cycle
  task automatic fetch_one(input int lat, input modePC m, input logic [PW-1:0] off, input bit h);
    int n;
    logic [IW-1:0] d;
    n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("req_wait",   64'(imem_req),  64'(1));
    check("fetch_addr", 64'(imem_addr), 64'(model_pc));
    for (int i = 0; i < lat; i++) begin
      drive_idle();
      @(negedge clk);
      check("req_held",    64'(imem_req),    64'(1));
      check("addr_stable", 64'(imem_addr),   64'(model_pc));
      check("no_valid",    64'(instr_valid), 64'(0));
    end
    d         = $urandom;
    imem_ack  = 1'b1;
    imem_data = d;
    exp_q.push_back(d);
    drive_idle();
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = $urandom;
    last_instr = exp_q.pop_front();
    check("exec_valid", 64'(instr_valid), 64'(1));
    check("exec_instr", 64'(instr),       64'(last_instr));
    check("exec_pc",    64'(pc),          64'(model_pc));
    check("exec_req",   64'(imem_req),    64'(0));
    check("exec_err",   64'(fetch_err),   64'(0));
    if (last_valid_cycle >= 0)
      check("exec_period", 64'(cycle - last_valid_cycle), 64'(lat + 2));
    last_valid_cycle = cycle;
    mode_pc   = m;
    offset    = off;
    halt_core = h;
    @(negedge clk);
    if (h || m == HALTCOUNT) begin
      check("halt_flag",  64'(halted),   64'(1));
      check("halt_pc",    64'(pc),       64'(model_pc));
      check("halt_req",   64'(imem_req), 64'(0));
      check("halt_state", 64'(state),    64'(S_HALT));
    end else begin
      model_pc = (model_pc + 1 + (m == RELATIVE ? int'($signed(off)) : 0)) & 255;
      check("run_halted", 64'(halted), 64'(0));
    end
    drive_idle();
  endtask

  task automatic go_to(input int target);
    fetch_one($urandom_range(0, 2), RELATIVE, PW'((target - model_pc - 1) & 255), 1'b0);
  endtask

  task automatic check_halted(input int cycles, input int hold_pc);
    for (int i = 0; i < cycles; i++) begin
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      drive_idle();
      @(negedge clk);
      check("hold_req",    64'(imem_req),    64'(0));
      check("hold_valid",  64'(instr_valid), 64'(0));
      check("hold_halted", 64'(halted),      64'(1));
      check("hold_pc",     64'(pc),          64'(hold_pc));
      check("hold_instr",  64'(instr),       64'(last_instr));
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    imem_ack  = 1'b0;
    imem_data = '0;
    drive_idle();
    repeat (2) @(negedge clk);
    do_reset(1'b0);

    // sequential INCREMENT fetches with one-cycle memory latency
    for (int i = 0; i < 4; i++) fetch_one(1, INCREMENT, PW'($urandom), 1'b0);
    fetch_one(0, INCREMENT, PW'($urandom), 1'b0);
    // relative branches, backward and forward, from pc=5
    fetch_one(1, RELATIVE, 8'hFD, 1'b0);
    fetch_one(2, RELATIVE, 8'h01, 1'b0);
    fetch_one(1, RELATIVE, 8'h04, 1'b0);
    // wrap-around at the top of the address space
    go_to(255);
    fetch_one(0, INCREMENT, PW'($urandom), 1'b0);
    go_to(254);
    fetch_one(1, RELATIVE, 8'h03, 1'b0);
`ifndef PICO_FETCH_TIMEOUT_EN
    fetch_one(20, INCREMENT, PW'($urandom), 1'b0);
`endif
    for (int i = 0; i < 16; i++)
      fetch_one($urandom_range(0, 3), modePC'(2'($urandom_range(0, 1))), PW'($urandom), 1'b0);

    // reset in the middle of a fetch at pc=9, with a late ack after release
    go_to(9);
    check("pre_rst_addr", 64'(imem_addr), 64'(9));
    check("pre_rst_req",  64'(imem_req),  64'(1));
    #2;
    do_reset(1'b1);

    // halt request wins over INCREMENT at pc=7
    for (int i = 0; i < 7; i++) fetch_one($urandom_range(0, 2), INCREMENT, PW'($urandom), 1'b0);
    fetch_one(1, INCREMENT, PW'($urandom), 1'b1);
    check_halted(20, 7);

    // HALTCOUNT halts with the PC unchanged
    @(negedge clk);
    do_reset(1'b0);
    fetch_one(0, INCREMENT, PW'($urandom), 1'b0);
    fetch_one(0, RELATIVE, 8'h05, 1'b0);
    fetch_one(1, HALTCOUNT, PW'($urandom), 1'b0);
    check_halted(5, 7);

`ifdef PICO_FETCH_TIMEOUT_EN
    // ack withheld: error and halt 15 cycles after req rises
    @(negedge clk);
    do_reset(1'b0);
    for (int i = 0; i < 14; i++) begin
      drive_idle();
      @(negedge clk);
      check("to_wait_err", 64'(fetch_err), 64'(0));
      check("to_wait_req", 64'(imem_req),  64'(1));
    end
    @(negedge clk);
    check("to_err",    64'(fetch_err), 64'(1));
    check("to_halted", 64'(halted),    64'(1));
    check("to_req",    64'(imem_req),  64'(0));
    check("to_pc",     64'(pc),        64'(0));
    // ack arriving in the 15th cycle is still captured normally
    @(negedge clk);
    do_reset(1'b0);
    fetch_one(14, INCREMENT, PW'($urandom), 1'b0);
    fetch_one(1, INCREMENT, PW'($urandom), 1'b0);
    check("late_ok_err", 64'(fetch_err), 64'(0));
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
